// File: rtl/and_gate_bist_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : and_gate_bist_ctrl_pkg
//  Description : Shared types, Gray vector table and width helpers for the
//                AND-gate BIST sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package and_gate_bist_ctrl_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } bist_state_t;

  // {a,b} vectors in Gray order: one input bit changes per step
  localparam logic [1:0] c_vec0 = 2'b00;
  localparam logic [1:0] c_vec1 = 2'b01;
  localparam logic [1:0] c_vec2 = 2'b11;
  localparam logic [1:0] c_vec3 = 2'b10;

  // Map a vector index to its {a,b} pattern
  function automatic logic [1:0] gray_vec(input logic [1:0] idx);
    logic [1:0] v;
    case (idx)
      2'd0:    v = c_vec0;
      2'd1:    v = c_vec1;
      2'd2:    v = c_vec2;
      default: v = c_vec3;
    endcase
    return v;
  endfunction

  // Bits needed to hold values 0..maxval (never less than one)
  function automatic int cnt_width(input int maxval);
    return (maxval < 1) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/and_gate_bist_ctrl_vecgen.sv
`default_nettype none
// ============================================================================
//  Module      : and_gate_bist_ctrl_vecgen
//  Description : Vector generator: settle / index / loop counters. Drives the
//                registered {a,b} pattern, a sample strobe on the last settle
//                cycle of each vector and a flag for the final vector.
//  Revision    : 1.0  initial release
// ============================================================================
module and_gate_bist_ctrl_vecgen
  import and_gate_bist_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int LOOPS         = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init,      // load the first vector, clear counters
  input  logic       en,        // sequencer is running this cycle
  input  logic       clr,       // cancel: park counters and drive 00
  output logic [1:0] vec,
  output logic       sample,
  output logic       last_vec
);

  localparam int c_sw = cnt_width(SETTLE_CYCLES);
  localparam int c_lw = cnt_width(LOOPS - 1);
  localparam logic [c_sw-1:0] c_settle_max = c_sw'(SETTLE_CYCLES);
  localparam logic [c_lw-1:0] c_loop_max   = c_lw'(LOOPS - 1);

  logic [c_sw-1:0] r_settle;
  logic [1:0]      r_idx;
  logic [c_lw-1:0] r_loop;
  logic [1:0]      r_vec;

  assign sample   = en && (r_settle == c_settle_max);
  assign last_vec = (r_idx == 2'd3) && (r_loop == c_loop_max);
  assign vec      = r_vec;

  // Step through settle cycles, then advance to the next Gray vector / pass
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_settle <= '0;
      r_idx    <= 2'd0;
      r_loop   <= '0;
      r_vec    <= 2'b00;
    end else if (init) begin
      r_settle <= '0;
      r_idx    <= 2'd0;
      r_loop   <= '0;
      r_vec    <= c_vec0;
    end else if (en) begin
      if (!sample) begin
        r_settle <= r_settle + 1'b1;
      end else begin
        r_settle <= '0;
        if (last_vec) begin
          // Run complete: release the gate inputs
          r_idx  <= 2'd0;
          r_loop <= '0;
          r_vec  <= 2'b00;
        end else begin
          r_idx <= r_idx + 2'd1;
          if (r_idx == 2'd3) r_loop <= r_loop + 1'b1;
          r_vec <= gray_vec(r_idx + 2'd1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/and_gate_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : and_gate_bist_ctrl
//  Description : BIST sequencer for a 2-input AND gate. Applies all four
//                input combinations in Gray order, checks y against a&b and
//                reports pass, a saturating error count and the first
//                failing vector.
//  Revision    : 1.0  initial release
// ============================================================================
module and_gate_bist_ctrl
  import and_gate_bist_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int LOOPS         = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             gate_y,
  output logic             gate_a,
  output logic             gate_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       first_fail_vec,
  output logic             fail_seen
);

  localparam logic [ERR_W-1:0] c_err_max = '1;

  bist_state_t r_state;

  logic       w_run;
  logic       w_init;
  logic       w_en;
  logic       w_abort;
  logic [1:0] w_vec;
  logic       w_sample;
  logic       w_last;
  logic       w_mismatch;

  assign w_run      = (r_state == ST_RUN);
  assign w_init     = start && !w_run;
  assign w_abort    = w_run && abort;
  assign w_en       = w_run && !abort;
  assign w_mismatch = w_sample && (gate_y != (w_vec[1] & w_vec[0]));

  assign gate_a = w_vec[1];
  assign gate_b = w_vec[0];

  and_gate_bist_ctrl_vecgen #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .LOOPS         (LOOPS)
  ) u_vecgen (
    .clk      (clk),
    .reset    (reset),
    .init     (w_init),
    .en       (w_en),
    .clr      (w_abort),
    .vec      (w_vec),
    .sample   (w_sample),
    .last_vec (w_last)
  );

  // Sequencer FSM plus checker and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_fail_vec <= 2'b00;
      fail_seen      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state        <= ST_RUN;
            busy           <= 1'b1;
            pass           <= 1'b0;
            err_count      <= '0;
            first_fail_vec <= 2'b00;
            fail_seen      <= 1'b0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (abort) begin
            // Partial error results are kept; no completion reported
            r_state <= ST_IDLE;
            busy    <= 1'b0;
            pass    <= 1'b0;
          end else if (w_sample) begin
            if (w_mismatch) begin
              if (err_count != c_err_max) err_count <= err_count + 1'b1;
              if (!fail_seen) begin
                fail_seen      <= 1'b1;
                first_fail_vec <= w_vec;
              end
            end
            if (w_last) begin
              r_state <= ST_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= !fail_seen && !w_mismatch;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_and_gate_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_and_gate_bist_ctrl
//  Description : Self-checking bench for and_gate_bist_ctrl. Three instances:
//                defaults, LOOPS=100 (saturation), SETTLE_CYCLES=0 (restart).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_and_gate_bist_ctrl;

  // gate behaviour models
  localparam int c_healthy = 0;
  localparam int c_stuck0  = 1;
  localparam int c_stuck1  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // instance 0: defaults
  logic reset0 = 1'b1, start0 = 1'b0, abort0 = 1'b0, y0;
  logic ga0, gb0, busy0, done0, pass0, fs0;
  logic [7:0] err0;
  logic [1:0] ffv0;
  int mode0 = c_healthy;

  // instance 1: LOOPS=100
  logic reset1 = 1'b1, start1 = 1'b0, abort1 = 1'b0, y1;
  logic ga1, gb1, busy1, done1, pass1, fs1;
  logic [7:0] err1;
  logic [1:0] ffv1;
  int mode1 = c_healthy;

  // instance 2: SETTLE_CYCLES=0
  logic reset2 = 1'b1, start2 = 1'b0, abort2 = 1'b0, y2;
  logic ga2, gb2, busy2, done2, pass2, fs2;
  logic [7:0] err2;
  logic [1:0] ffv2;
  int mode2 = c_healthy;

  function automatic logic gate_model(input int mode, input logic a, input logic b);
    if (mode == c_stuck0) return 1'b0;
    if (mode == c_stuck1) return 1'b1;
    return a & b;
  endfunction

  assign y0 = gate_model(mode0, ga0, gb0);
  assign y1 = gate_model(mode1, ga1, gb1);
  assign y2 = gate_model(mode2, ga2, gb2);

  and_gate_bist_ctrl u0 (
    .clk(clk), .reset(reset0), .start(start0), .abort(abort0), .gate_y(y0),
    .gate_a(ga0), .gate_b(gb0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .first_fail_vec(ffv0), .fail_seen(fs0)
  );

  and_gate_bist_ctrl #(.SETTLE_CYCLES(2), .LOOPS(100), .ERR_W(8)) u1 (
    .clk(clk), .reset(reset1), .start(start1), .abort(abort1), .gate_y(y1),
    .gate_a(ga1), .gate_b(gb1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail_vec(ffv1), .fail_seen(fs1)
  );

  and_gate_bist_ctrl #(.SETTLE_CYCLES(0), .LOOPS(1), .ERR_W(8)) u2 (
    .clk(clk), .reset(reset2), .start(start2), .abort(abort2), .gate_y(y2),
    .gate_a(ga2), .gate_b(gb2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .first_fail_vec(ffv2), .fail_seen(fs2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         mode;
    logic       exp_pass;
    logic [7:0] exp_err;
    logic       exp_fs;
    logic [1:0] exp_ffv;
  } vec_t;

  vec_t tbl[3];

  // One full default run on u0; start pulse lands on edge E0
  task automatic run_u0(input int i);
    int         done_at;
    int         done_cnt;
    logic [7:0] seq;
    logic [1:0] bz;
    logic [1:0] gate_end;
    done_at  = 0;
    done_cnt = 0;
    seq      = 8'h00;
    bz       = 2'b00;
    gate_end = 2'b11;
    mode0    = tbl[i].mode;
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;          // just after E0
    seq = {seq[5:0], ga0, gb0};
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);                      // just after E0+k
      if (k == 3 || k == 6 || k == 9) seq = {seq[5:0], ga0, gb0};
      if (k == 11) bz[1] = busy0;
      if (k == 12) begin
        bz[0]    = busy0;
        gate_end = {ga0, gb0};
      end
      if (done0) begin
        done_cnt++;
        if (done_at == 0) done_at = k;
      end
    end
    check($sformatf("run%0d_done_at", i),   done_at, 12);
    check($sformatf("run%0d_done_cnt", i),  done_cnt, 1);
    check($sformatf("run%0d_gate_seq", i),  seq, 8'h1E);
    check($sformatf("run%0d_busy_edge", i), bz, 2'b10);
    check($sformatf("run%0d_gate_end", i),  gate_end, 2'b00);
    check($sformatf("run%0d_pass", i),      pass0, tbl[i].exp_pass);
    check($sformatf("run%0d_err", i),       err0, tbl[i].exp_err);
    check($sformatf("run%0d_fail_seen", i), fs0, tbl[i].exp_fs);
    check($sformatf("run%0d_ffv", i),       ffv0, tbl[i].exp_ffv);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_at;
    int done_cnt;

    tbl[0] = '{mode: c_stuck0,  exp_pass: 1'b0, exp_err: 8'd1, exp_fs: 1'b1, exp_ffv: 2'b11};
    tbl[1] = '{mode: c_stuck1,  exp_pass: 1'b0, exp_err: 8'd3, exp_fs: 1'b1, exp_ffv: 2'b00};
    tbl[2] = '{mode: c_healthy, exp_pass: 1'b1, exp_err: 8'd0, exp_fs: 1'b0, exp_ffv: 2'b00};

    // power-on reset
    repeat (3) @(negedge clk);
    reset0 = 1'b0; reset1 = 1'b0; reset2 = 1'b0;
    @(negedge clk);
    check("reset_u0_flags", {busy0, done0, pass0, fs0, ga0, gb0}, 6'b0);
    check("reset_u0_err", err0, 8'd0);
    check("reset_u0_ffv", ffv0, 2'b00);
    check("reset_u1_u2_flags", {busy1, done1, pass1, fs1, ga1, gb1,
                                busy2, done2, pass2, fs2, ga2, gb2}, 12'b0);

    // table-driven default runs
    for (int i = 0; i < 3; i++) run_u0(i);

    // abort at E0+5 -> IDLE after E0+6
    mode0 = c_stuck1;
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    repeat (5) @(negedge clk);
    abort0 = 1'b1;
    @(negedge clk) abort0 = 1'b0;
    check("abort_outputs", {busy0, done0, pass0, ga0, gb0}, 5'b0);
    check("abort_partial", {fs0, ffv0}, 3'b100);
    done_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done0) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    check("abort_idle_busy", busy0, 1'b0);

    // same with reset mid-run
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    repeat (5) @(negedge clk);
    reset0 = 1'b1;
    @(negedge clk) reset0 = 1'b0;
    check("midreset_flags", {busy0, done0, pass0, fs0, ga0, gb0}, 6'b0);
    check("midreset_err_ffv", {err0, ffv0}, 10'b0);
    done_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done0) done_cnt++;
    end
    check("midreset_no_done", done_cnt, 0);

    // start and abort together in IDLE: start wins
    mode0 = c_healthy;
    @(negedge clk) begin start0 = 1'b1; abort0 = 1'b1; end
    @(negedge clk) begin start0 = 1'b0; abort0 = 1'b0; end
    check("start_beats_abort", {busy0, ga0, gb0}, 3'b100);
    done_cnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done0) done_cnt++;
    end
    check("start_beats_abort_done", {done_cnt[3:0], pass0}, 5'b00011);

    // LOOPS=100, stuck-at-1: saturation, done at E0+1200
    mode1 = c_stuck1;
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    done_at = 0;
    for (int k = 1; k <= 1300 && done_at == 0; k++) begin
      @(negedge clk);
      if (done1) done_at = k;
    end
    check("sat_done_at", done_at, 1200);
    check("sat_err", err1, 8'd255);
    check("sat_result", {pass1, fs1, ffv1}, 4'b0100);

    // SETTLE_CYCLES=0, start held: period of 5 with one DONE cycle
    mode2 = c_healthy;
    @(negedge clk) start2 = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);                      // just after E0+k
      check($sformatf("hold_k%0d_busy_done", k), {busy2, done2},
            (k % 5 == 4) ? 2'b01 : 2'b10);
      if (k == 4) check("hold_pass", pass2, 1'b1);
    end
    start2 = 1'b0;

    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
